// File: rtl/riscv_pkg.sv
// riscv_pkg: shared LSU width, FSM state and error encodings
package riscv_pkg;
  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_width_e;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RV} lsu_state_e;
  typedef enum logic [1:0] {
    LSU_ERR_NONE,
    LSU_ERR_MISALIGN,
    LSU_ERR_BUS,
    LSU_ERR_TIMEOUT
  } lsu_err_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane replication and load extract/extension
module lsu_align (
  input  logic [2:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [31:0] b_sh, h_sh;
  logic        sx_b, sx_h;
  always_comb begin
    b_sh      = rdata >> {addr_lo, 3'b000};
    h_sh      = rdata >> {addr_lo[1], 4'b0000};
    sx_b      = ~width[2] & b_sh[7];
    sx_h      = ~width[2] & h_sh[15];
    be        = width[1] ? 4'b1111 : width[0] ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b0001 << addr_lo;
    wdata_rep = width[1] ? wdata : width[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    rdata_ext = width[1] ? rdata : width[0] ? {{16{sx_h}}, h_sh[15:0]} : {{24{sx_b}}, b_sh[7:0]};
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage driving a req/gnt/rvalid data bus and the registered WB port
module mem_stage
  import riscv_pkg::*;
#(
  parameter int GNT_TIMEOUT = 256,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_lsu_valid,
  input  logic        mem_lsu_wr_type,
  input  logic [2:0]  mem_lsu_width_type,
  input  logic [31:0] mem_lsu_addr,
  input  logic [31:0] mem_lsu_wdata,
  input  logic        mem_dest_we_valid,
  input  logic [4:0]  mem_dest_we_addr,
  input  logic [31:0] mem_dest_we_data,
  output logic        mem_stage_ready,
  output logic        data_req,
  input  logic        data_gnt,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_rvalid,
  input  logic [31:0] data_rdata,
  input  logic        data_err,
  output logic        wb_dest_we_valid,
  output logic [4:0]  wb_dest_we_addr,
  output logic [31:0] wb_dest_we_data,
  output logic        lsu_err_valid,
  output logic [1:0]  lsu_err_code,
  output logic [31:0] lsu_err_addr
);
  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             req_we, cur_we;
  logic [2:0]       req_width, cur_width;
  logic [31:0]      req_addr, req_wdata, cur_addr, cur_wdata, rdata_ext;
  logic [4:0]       req_dest;
  logic             idle, bad, start, timeout;
  assign idle    = state == IDLE;
  assign bad     = mem_lsu_width_type == 3'b011 || mem_lsu_width_type[2:1] == 2'b11
                || (mem_lsu_wr_type && mem_lsu_width_type[2])
                || (mem_lsu_width_type[1:0] == 2'b01 && mem_lsu_addr[0])
                || (mem_lsu_width_type == LSU_W && mem_lsu_addr[1:0] != 2'b00);
  assign start   = idle && mem_lsu_valid && !bad;
  assign timeout = state == WAIT_GNT && !data_gnt && cnt == CNT_W'(GNT_TIMEOUT - 1);
  assign data_req        = !reset && (start || state == WAIT_GNT);
  assign mem_stage_ready = idle ? !start : state == WAIT_GNT ? timeout : data_rvalid;
  // The bus is fed straight from EX while idle, from the captured request afterwards
  assign {cur_we, cur_width, cur_addr, cur_wdata} = idle
    ? {mem_lsu_wr_type, mem_lsu_width_type, mem_lsu_addr, mem_lsu_wdata}
    : {req_we, req_width, req_addr, req_wdata};
  assign data_we   = cur_we;
  assign data_addr = {cur_addr[31:2], 2'b00};
  lsu_align u_align (
    .width     (cur_width),
    .addr_lo   (cur_addr[1:0]),
    .wdata     (cur_wdata),
    .rdata     (data_rdata),
    .be        (data_be),
    .wdata_rep (data_wdata),
    .rdata_ext (rdata_ext)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      {req_we, req_width, req_addr, req_wdata, req_dest} <= '0;
      {wb_dest_we_valid, wb_dest_we_addr, wb_dest_we_data} <= '0;
      {lsu_err_valid, lsu_err_code, lsu_err_addr} <= '0;
    end else begin
      wb_dest_we_valid <= 1'b0;
      lsu_err_valid    <= 1'b0;
      case (state)
        IDLE:
          if (!mem_lsu_valid) begin
            {wb_dest_we_valid, wb_dest_we_addr, wb_dest_we_data} <= {mem_dest_we_valid, mem_dest_we_addr, mem_dest_we_data};
          end else if (bad) begin
            lsu_err_valid <= 1'b1;
            lsu_err_code  <= LSU_ERR_MISALIGN;
            lsu_err_addr  <= mem_lsu_addr;
          end else begin
            state <= data_gnt ? WAIT_RV : WAIT_GNT;
            {req_we, req_width, req_addr, req_wdata, req_dest} <= {mem_lsu_wr_type, mem_lsu_width_type, mem_lsu_addr, mem_lsu_wdata, mem_dest_we_addr};
          end
        WAIT_GNT: begin
          cnt <= (data_gnt || timeout) ? '0 : cnt + 1'b1;
          if (data_gnt) begin
            state <= WAIT_RV;
          end else if (timeout) begin
            state         <= IDLE;
            lsu_err_valid <= 1'b1;
            lsu_err_code  <= LSU_ERR_TIMEOUT;
            lsu_err_addr  <= req_addr;
          end
        end
        WAIT_RV:
          if (data_rvalid) begin
            state <= IDLE;
            if (data_err) begin
              lsu_err_valid <= 1'b1;
              lsu_err_code  <= LSU_ERR_BUS;
              lsu_err_addr  <= req_addr;
            end else if (!req_we) begin
              {wb_dest_we_valid, wb_dest_we_addr, wb_dest_we_data} <= {1'b1, req_dest, rdata_ext};
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven and scoreboarded checks of the memory stage
module tb_mem_stage;
  import riscv_pkg::*;
  logic        clk, reset;
  logic        mem_lsu_valid, mem_lsu_wr_type;
  logic [2:0]  mem_lsu_width_type;
  logic [31:0] mem_lsu_addr, mem_lsu_wdata;
  logic        mem_dest_we_valid;
  logic [4:0]  mem_dest_we_addr;
  logic [31:0] mem_dest_we_data;
  logic        mem_stage_ready, data_req, data_gnt, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        wb_dest_we_valid;
  logic [4:0]  wb_dest_we_addr;
  logic [31:0] wb_dest_we_data;
  logic        lsu_err_valid;
  logic [1:0]  lsu_err_code;
  logic [31:0] lsu_err_addr;
  int checks = 0, failures = 0;
  logic [36:0] wb_q[$];
  logic [33:0] err_q[$];
  typedef struct {
    logic        we;
    logic [2:0]  width;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    int          dly;
    logic        bad;
    logic [3:0]  be;
    logic [31:0] ewd, exp;
  } vec_t;
  vec_t vecs[17];
  vec_t ld;
  mem_stage dut (
    .clk                (clk),
    .reset              (reset),
    .mem_lsu_valid      (mem_lsu_valid),
    .mem_lsu_wr_type    (mem_lsu_wr_type),
    .mem_lsu_width_type (mem_lsu_width_type),
    .mem_lsu_addr       (mem_lsu_addr),
    .mem_lsu_wdata      (mem_lsu_wdata),
    .mem_dest_we_valid  (mem_dest_we_valid),
    .mem_dest_we_addr   (mem_dest_we_addr),
    .mem_dest_we_data   (mem_dest_we_data),
    .mem_stage_ready    (mem_stage_ready),
    .data_req           (data_req),
    .data_gnt           (data_gnt),
    .data_we            (data_we),
    .data_be            (data_be),
    .data_addr          (data_addr),
    .data_wdata         (data_wdata),
    .data_rvalid        (data_rvalid),
    .data_rdata         (data_rdata),
    .data_err           (data_err),
    .wb_dest_we_valid   (wb_dest_we_valid),
    .wb_dest_we_addr    (wb_dest_we_addr),
    .wb_dest_we_data    (wb_dest_we_data),
    .lsu_err_valid      (lsu_err_valid),
    .lsu_err_code       (lsu_err_code),
    .lsu_err_addr       (lsu_err_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [36:0] w;
    logic [33:0] e;
    if (wb_dest_we_valid) begin
      if (wb_q.size() == 0) chk("wb_unexpected", {wb_dest_we_addr, wb_dest_we_data}, 64'h0);
      else begin
        w = wb_q.pop_front();
        chk("wb", {wb_dest_we_addr, wb_dest_we_data}, w);
      end
    end
    if (lsu_err_valid) begin
      if (err_q.size() == 0) chk("err_unexpected", {lsu_err_code, lsu_err_addr}, 64'h0);
      else begin
        e = err_q.pop_front();
        chk("err", {lsu_err_code, lsu_err_addr}, e);
      end
    end
  end
  task automatic scramble(input vec_t v, input logic [4:0] dest);
    mem_lsu_addr       = ~v.addr;
    mem_lsu_width_type = 3'b010;
    mem_lsu_wr_type    = ~v.we;
    mem_lsu_wdata      = ~v.wdata;
    mem_dest_we_addr   = ~dest;
  endtask
  task automatic access(input vec_t v, input logic [4:0] dest);
    mem_lsu_valid      = 1'b1;
    mem_lsu_wr_type    = v.we;
    mem_lsu_width_type = v.width;
    mem_lsu_addr       = v.addr;
    mem_lsu_wdata      = v.wdata;
    mem_dest_we_valid  = 1'b0;
    mem_dest_we_addr   = dest;
    data_gnt           = v.dly == 0;
    #1;
    if (v.bad) begin
      chk("bad_req_ready", {data_req, mem_stage_ready}, 2'b01);
      err_q.push_back({LSU_ERR_MISALIGN, v.addr});
    end else begin
      chk("req_bus", {data_req, mem_stage_ready, data_we, data_be, data_addr}, {1'b1, 1'b0, v.we, v.be, v.addr & ~32'h3});
      if (v.we) chk("req_wdata", data_wdata, v.ewd);
      for (int i = 0; i < v.dly; i++) begin
        @(negedge clk);
        data_gnt = i == v.dly - 1;
        scramble(v, dest);
        #1;
        chk("wait_bus", {data_req, mem_stage_ready, data_we, data_be, data_addr}, {1'b1, 1'b0, v.we, v.be, v.addr & ~32'h3});
        if (v.we) chk("wait_wdata", data_wdata, v.ewd);
      end
      @(negedge clk);
      scramble(v, dest);
      data_gnt    = 1'b0;
      data_rvalid = 1'b1;
      data_rdata  = v.rdata;
      data_err    = v.err;
      #1;
      chk("rv_ready", {data_req, mem_stage_ready}, 2'b01);
      if (v.err) err_q.push_back({LSU_ERR_BUS, v.addr});
      else if (!v.we) wb_q.push_back({dest, v.exp});
    end
    @(negedge clk);
    mem_lsu_valid = 1'b0;
    data_rvalid   = 1'b0;
    data_err      = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    logic held;
    clk = 0; reset = 1;
    mem_lsu_valid = 1; mem_lsu_wr_type = 0; mem_lsu_width_type = LSU_W;
    mem_lsu_addr = 32'h100; mem_lsu_wdata = 0;
    mem_dest_we_valid = 0; mem_dest_we_addr = 0; mem_dest_we_data = 0;
    data_gnt = 0; data_rvalid = 0; data_rdata = 0; data_err = 0;
    //             we  width   addr        wdata         rdata         err dly bad be       ewd           exp
    vecs[0]  = '{1'b1, LSU_W,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, LSU_B,  32'h203, 32'h0,        32'h80FF1234, 1'b0, 0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{1'b0, LSU_BU, 32'h203, 32'h0,        32'h80FF1234, 1'b0, 0, 1'b0, 4'b1000, 32'h0, 32'h00000080};
    vecs[3]  = '{1'b0, LSU_HU, 32'h202, 32'h0,        32'h80FF1234, 1'b0, 0, 1'b0, 4'b1100, 32'h0, 32'h000080FF};
    vecs[4]  = '{1'b1, LSU_B,  32'h11,  32'hA5,       32'h0,        1'b0, 0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[5]  = '{1'b1, LSU_H,  32'h12,  32'h1234,     32'h0,        1'b0, 0, 1'b0, 4'b1100, 32'h12341234, 32'h0};
    vecs[6]  = '{1'b0, LSU_W,  32'h6,   32'h0,        32'h0,        1'b0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, LSU_W,  32'h40,  32'h0,        32'h12345678, 1'b0, 3, 1'b0, 4'b1111, 32'h0, 32'h12345678};
    vecs[8]  = '{1'b0, LSU_H,  32'h42,  32'h0,        32'h80017FFF, 1'b0, 1, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001};
    vecs[9]  = '{1'b0, LSU_H,  32'h40,  32'h0,        32'h80017FFF, 1'b0, 0, 1'b0, 4'b0011, 32'h0, 32'h00007FFF};
    vecs[10] = '{1'b0, LSU_B,  32'h41,  32'h0,        32'h0000A57F, 1'b0, 0, 1'b0, 4'b0010, 32'h0, 32'hFFFFFFA5};
    vecs[11] = '{1'b0, LSU_W,  32'h50,  32'h0,        32'h11111111, 1'b1, 0, 1'b0, 4'b1111, 32'h0, 32'h0};
    vecs[12] = '{1'b1, LSU_W,  32'h60,  32'hCAFEBABE, 32'h0,        1'b1, 2, 1'b0, 4'b1111, 32'hCAFEBABE, 32'h0};
    vecs[13] = '{1'b1, LSU_BU, 32'h70,  32'h0,        32'h0,        1'b0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[14] = '{1'b1, LSU_H,  32'h13,  32'h0,        32'h0,        1'b0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[15] = '{1'b0, LSU_HU, 32'h21,  32'h0,        32'h0,        1'b0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[16] = '{1'b1, LSU_B,  32'h7,   32'h123456C3, 32'h0,        1'b0, 0, 1'b0, 4'b1000, 32'hC3C3C3C3, 32'h0};
    @(negedge clk); #1;
    chk("rst_data_req", data_req, 1'b0);
    @(negedge clk); #1;
    chk("rst_outputs", {wb_dest_we_valid, wb_dest_we_addr, wb_dest_we_data, lsu_err_valid, lsu_err_code}, 64'h0);
    chk("rst_err_addr", lsu_err_addr, 32'h0);
    mem_lsu_valid = 0;
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) access(vecs[i], 5'(i + 1));
    mem_dest_we_valid = 1; mem_dest_we_addr = 5'd7; mem_dest_we_data = 32'h111;
    wb_q.push_back({5'd7, 32'h111});
    @(negedge clk);
    ld = '{1'b0, LSU_W, 32'h80, 32'h0, 32'hCAFEF00D, 1'b0, 0, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D};
    access(ld, 5'd8);
    mem_dest_we_valid = 1; mem_dest_we_addr = 5'd0; mem_dest_we_data = 32'h333;
    wb_q.push_back({5'd0, 32'h333});
    @(negedge clk);
    mem_dest_we_valid = 0;
    @(negedge clk); #1;
    chk("wb_deassert", wb_dest_we_valid, 1'b0);
    mem_lsu_valid = 1; mem_lsu_wr_type = 0; mem_lsu_width_type = LSU_W;
    mem_lsu_addr = 32'h300; mem_dest_we_addr = 5'd3; data_gnt = 0;
    #1;
    chk("to_first", {data_req, mem_stage_ready}, 2'b10);
    n = 0; held = 1;
    do begin
      @(negedge clk); #1;
      n++;
      held &= data_req;
    end while (!mem_stage_ready && n < 300);
    chk("timeout_cycles", n, 256);
    chk("timeout_req_held", held, 1'b1);
    err_q.push_back({LSU_ERR_TIMEOUT, 32'h300});
    @(negedge clk);
    mem_lsu_valid = 0;
    #1;
    chk("timeout_idle", {data_req, mem_stage_ready}, 2'b01);
    @(negedge clk);
    mem_lsu_valid = 1; mem_lsu_addr = 32'h90; mem_dest_we_addr = 5'd4; data_gnt = 1;
    @(negedge clk);
    data_gnt = 0; mem_lsu_valid = 0; reset = 1;
    #1;
    chk("rst_mid_req", data_req, 1'b0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_mid_idle", mem_stage_ready, 1'b1);
    data_rvalid = 1; data_rdata = 32'h5555AAAA;
    @(negedge clk);
    data_rvalid = 0;
    #1;
    chk("late_rvalid_no_wb", wb_dest_we_valid, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    chk("wb_queue_empty", wb_q.size(), 0);
    chk("err_queue_empty", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
